// File: rtl/ddr_burst_reader.sv
// ddr_burst_reader
//   Services the HDMI-out FIFO fill FSM. Each go_fill_fifo pulse becomes one
//   IPIF master read burst of BURST_WORDS 32-bit words. Returned beats are
//   pushed into the pixel FIFO. When a burst has fully landed without error,
//   a one-cycle half_full pulse is raised so the fill FSM can advance.
//
// Ports
//   Bus2IP_Clk / Bus2IP_Resetn      clock, async active-low reset
//   go_fill_fifo, ddr_addr_to_read  burst request and byte address
//   IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length
//                                   master read command
//   Bus2IP_Mst_CmdAck / _Cmplt / _Error
//                                   command handshake and completion
//   Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n, IP2Bus_MstRd_dst_rdy_n
//                                   read data channel (active-low ready)
//   fifo_almost_full, fifo_wr_en, fifo_wr_data
//                                   pixel FIFO write side
//   half_full    pulse: burst landed cleanly
//   busy         high outside IDLE
//   rd_error     sticky: error or short completion seen
//   req_overrun  sticky: pending request overwritten
//
// All outputs are registered. A request arriving while busy is parked in a
// 1-deep pending slot and launched straight from DONE.
module ddr_burst_reader #(
  parameter int BURST_WORDS = 64
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Resetn,
  input  logic        go_fill_fifo,
  input  logic [31:0] ddr_addr_to_read,
  output logic        IP2Bus_MstRd_Req,
  output logic [31:0] IP2Bus_Mst_Addr,
  output logic [11:0] IP2Bus_Mst_Length,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic        Bus2IP_Mst_Cmplt,
  input  logic        Bus2IP_Mst_Error,
  input  logic [31:0] Bus2IP_MstRd_d,
  input  logic        Bus2IP_MstRd_src_rdy_n,
  output logic        IP2Bus_MstRd_dst_rdy_n,
  input  logic        fifo_almost_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        half_full,
  output logic        busy,
  output logic        rd_error,
  output logic        req_overrun
);

  localparam int              CW   = $clog2(BURST_WORDS + 1);
  localparam logic [CW-1:0]   LAST = CW'(BURST_WORDS);
  localparam logic [11:0]     LEN  = 12'(BURST_WORDS * 4);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [11:0]   len_q, len_d;
  logic          dst_rdy_n_q, dst_rdy_n_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          half_full_q, half_full_d;
  logic          busy_q, busy_d;
  logic          rd_error_q, rd_error_d;
  logic          overrun_q, overrun_d;

  logic [31:0]   go_addr;
  logic          beat;

  assign go_addr = {ddr_addr_to_read[31:2], 2'b00};
  // dst_rdy_n_q is only ever low in XFER, so it gates the handshake alone.
  assign beat    = (state_q == XFER) && !Bus2IP_MstRd_src_rdy_n && !dst_rdy_n_q;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go_fill_fifo)      state_d = REQ;
      REQ:  if (Bus2IP_Mst_CmdAck) state_d = XFER;
      XFER: if (Bus2IP_Mst_Cmplt)  state_d = DONE;
      // A go landing in the DONE cycle is treated as already pending.
      DONE: state_d = (pend_q || go_fill_fifo) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- outputs / datapath
  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    beat_cnt_d  = beat_cnt_q;
    rd_error_d  = rd_error_q;
    overrun_d   = overrun_q;
    half_full_d = 1'b0;
    wr_en_d     = beat;
    wr_data_d   = beat ? Bus2IP_MstRd_d : wr_data_q;

    if (beat) beat_cnt_d = beat_cnt_q + CW'(1);

    if (go_fill_fifo && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_addr_d = go_addr;
      if (pend_q) overrun_d = 1'b1;
    end

    // Command setup on REQ entry: from IDLE take the live address, from DONE
    // take the pending slot (which already reflects a same-cycle go).
    if (state_d == REQ && state_q != REQ) begin
      beat_cnt_d = '0;
      len_d      = LEN;
      if (state_q == IDLE) begin
        addr_d = go_addr;
      end else begin
        addr_d = pend_addr_d;
        pend_d = 1'b0;
      end
    end

    // Completion outcome is resolved on the XFER->DONE edge so the pulse is
    // visible during the DONE cycle; a last beat on the Cmplt cycle counts.
    if (state_q == XFER && state_d == DONE) begin
      if (!Bus2IP_Mst_Error && beat_cnt_d == LAST) half_full_d = 1'b1;
      else                                         rd_error_d  = 1'b1;
    end

    req_d       = (state_d == REQ);
    busy_d      = (state_d != IDLE);
    // Ready looks one cycle ahead; a late almost_full still lets one beat in,
    // which the FIFO's last free slot absorbs.
    dst_rdy_n_d = (state_d != XFER) || fifo_almost_full || (beat_cnt_d == LAST);
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      beat_cnt_q  <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      dst_rdy_n_q <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      half_full_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_error_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      dst_rdy_n_q <= dst_rdy_n_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      half_full_q <= half_full_d;
      busy_q      <= busy_d;
      rd_error_q  <= rd_error_d;
      overrun_q   <= overrun_d;
    end
  end

  assign IP2Bus_MstRd_Req       = req_q;
  assign IP2Bus_Mst_Addr        = addr_q;
  assign IP2Bus_Mst_Length      = len_q;
  assign IP2Bus_MstRd_dst_rdy_n = dst_rdy_n_q;
  assign fifo_wr_en             = wr_en_q;
  assign fifo_wr_data           = wr_data_q;
  assign half_full              = half_full_q;
  assign busy                   = busy_q;
  assign rd_error               = rd_error_q;
  assign req_overrun            = overrun_q;

endmodule

// File: tb/tb_ddr_burst_reader.sv
`timescale 1ns/1ps
module tb_ddr_burst_reader;
  localparam int BW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go_fill_fifo = 1'b0;
  logic [31:0] ddr_addr_to_read = '0;
  logic        IP2Bus_MstRd_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [11:0] IP2Bus_Mst_Length;
  logic        Bus2IP_Mst_CmdAck = 1'b0;
  logic        Bus2IP_Mst_Cmplt = 1'b0;
  logic        Bus2IP_Mst_Error = 1'b0;
  logic [31:0] Bus2IP_MstRd_d = '0;
  logic        Bus2IP_MstRd_src_rdy_n = 1'b1;
  logic        IP2Bus_MstRd_dst_rdy_n;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        half_full, busy, rd_error, req_overrun;

  always #5 clk = ~clk;

  ddr_burst_reader #(.BURST_WORDS(BW)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
    .go_fill_fifo(go_fill_fifo), .ddr_addr_to_read(ddr_addr_to_read),
    .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr),
    .IP2Bus_Mst_Length(IP2Bus_Mst_Length), .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt), .Bus2IP_Mst_Error(Bus2IP_Mst_Error),
    .Bus2IP_MstRd_d(Bus2IP_MstRd_d), .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
    .IP2Bus_MstRd_dst_rdy_n(IP2Bus_MstRd_dst_rdy_n), .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .half_full(half_full),
    .busy(busy), .rd_error(rd_error), .req_overrun(req_overrun)
  );

  int tests = 0, fails = 0;
  int hf_cnt = 0, exp_hf = 0;
  logic [31:0] wr_q[$];   // what the DUT wrote into the FIFO
  logic [31:0] exp_q[$];  // words the bus slave handed over, in order

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
      if (half_full) hf_cnt++;
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    int mism;
    int n;
    mism = 0;
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    chk32({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) if (wr_q[i] !== exp_q[i]) mism++;
    chk32({tag, "_wr_data_mismatches"}, 32'(mism), 32'd0);
    wr_q.delete();
    exp_q.delete();
  endtask

  // Pulse go from IDLE; command must be up on the very next cycle.
  task automatic send_go(input logic [31:0] a);
    @(negedge clk);
    go_fill_fifo = 1'b1;
    ddr_addr_to_read = a;
    @(negedge clk);
    go_fill_fifo = 1'b0;
    chk1("req_next_cycle", IP2Bus_MstRd_Req, 1'b1);
    chk1("busy_after_go", busy, 1'b1);
  endtask

  // Bus slave for one burst. g1/g2 inject go pulses on the given XFER cycle.
  // abort_at >= 0 returns as soon as that many beats have been accepted.
  task automatic do_burst(input logic [31:0] addr, input int nbeats, input bit err,
                          input bit af_mode, input int ack_dly, input int abort_at,
                          input int g1, input logic [31:0] a1,
                          input int g2, input logic [31:0] a2);
    int cnt, sent, cyc;
    bit acc, cm, fin, aborted;
    logic [31:0] cur;
    cnt = 0;
    while (IP2Bus_MstRd_Req !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk1("req_seen", IP2Bus_MstRd_Req, 1'b1);
    chk32("req_addr", IP2Bus_Mst_Addr, {addr[31:2], 2'b00});
    chk32("req_len", 32'(IP2Bus_Mst_Length), 32'(BW * 4));
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk1("hold_req", IP2Bus_MstRd_Req, 1'b1);
      chk32("hold_addr", IP2Bus_Mst_Addr, {addr[31:2], 2'b00});
      chk32("hold_len", 32'(IP2Bus_Mst_Length), 32'(BW * 4));
      chk1("no_rdy_before_ack", IP2Bus_MstRd_dst_rdy_n, 1'b1);
    end
    Bus2IP_Mst_CmdAck = 1'b1;
    @(negedge clk);
    Bus2IP_Mst_CmdAck = 1'b0;
    chk1("req_drop_after_ack", IP2Bus_MstRd_Req, 1'b0);

    sent = 0; cyc = 0; fin = 0; aborted = 0;
    cur = $urandom;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (sent == abort_at) begin aborted = 1; break; end
      if (cyc > 3000) begin
        chk32("xfer_timeout_beats", 32'(sent), 32'(nbeats));
        break;
      end
      go_fill_fifo = (cyc == g1) || (cyc == g2);
      ddr_addr_to_read = (cyc == g2) ? a2 : a1;
      fifo_almost_full = af_mode ? (((cyc / 3) % 2) == 1) : 1'b0;
      if (sent < nbeats) begin
        Bus2IP_MstRd_src_rdy_n = ($urandom_range(0, 3) == 0);
        Bus2IP_MstRd_d = cur;
      end else begin
        Bus2IP_MstRd_src_rdy_n = 1'b1;
      end
      acc = !Bus2IP_MstRd_src_rdy_n && !IP2Bus_MstRd_dst_rdy_n;
      cm = 1'b0;
      // Completion either rides the last beat or follows it later.
      if (sent + int'(acc) == nbeats) cm = acc ? bit'($urandom_range(0, 1)) : 1'b1;
      Bus2IP_Mst_Cmplt = cm;
      Bus2IP_Mst_Error = cm & err;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(cur);
        sent++;
        cur = $urandom;
      end
      if (cm) fin = 1;
    end
    if (!aborted) @(negedge clk);
    go_fill_fifo = 1'b0;
    Bus2IP_MstRd_src_rdy_n = 1'b1;
    Bus2IP_Mst_Cmplt = 1'b0;
    Bus2IP_Mst_Error = 1'b0;
    fifo_almost_full = 1'b0;
    if (fin) begin
      chk1("done_half_full", half_full, (!err && nbeats == BW));
      chk1("done_busy", busy, 1'b1);
    end
  endtask

  logic [31:0] ra, rb, rc;

  initial begin
    // ---- reset state
    repeat (3) @(negedge clk);
    chk1("rst_req", IP2Bus_MstRd_Req, 1'b0);
    chk32("rst_addr", IP2Bus_Mst_Addr, 32'h0);
    chk32("rst_len", 32'(IP2Bus_Mst_Length), 32'h0);
    chk1("rst_dst_rdy_n", IP2Bus_MstRd_dst_rdy_n, 1'b1);
    chk1("rst_wr_en", fifo_wr_en, 1'b0);
    chk1("rst_half_full", half_full, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rd_error", rd_error, 1'b0);
    chk1("rst_overrun", req_overrun, 1'b0);
    rst_n = 1'b1;

    // ---- 1: basic burst, unaligned address is masked
    send_go(32'h1000_0003);
    do_burst(32'h1000_0003, BW, 0, 0, 0, -1, -1, 0, -1, 0);
    exp_hf++;
    @(negedge clk);
    chk1("t1_busy_low", busy, 1'b0);
    @(negedge clk);
    check_writes("t1");
    chk32("t1_hf_count", 32'(hf_cnt), 32'(exp_hf));

    // ---- 2: slow command acknowledge
    ra = $urandom;
    send_go(ra);
    do_burst(ra, BW, 0, 0, 10, -1, -1, 0, -1, 0);
    exp_hf++;
    repeat (2) @(negedge clk);
    check_writes("t2");
    chk32("t2_hf_count", 32'(hf_cnt), 32'(exp_hf));

    // ---- 3: FIFO almost-full toggling
    ra = $urandom;
    send_go(ra);
    do_burst(ra, BW, 0, 1, $urandom_range(0, 3), -1, -1, 0, -1, 0);
    exp_hf++;
    repeat (2) @(negedge clk);
    check_writes("t3");
    chk32("t3_hf_count", 32'(hf_cnt), 32'(exp_hf));

    // ---- 4: two requests during a burst, second overwrites the first
    ra = $urandom; rb = $urandom; rc = $urandom;
    send_go(ra);
    do_burst(ra, BW, 0, 0, 1, -1, 5, rb, 12, rc);
    exp_hf++;
    chk1("t4_overrun", req_overrun, 1'b1);
    do_burst(rc, BW, 0, 0, 2, -1, -1, 0, -1, 0);
    exp_hf++;
    repeat (3) @(negedge clk);
    chk1("t4_busy_low", busy, 1'b0);
    chk1("t4_no_third_req", IP2Bus_MstRd_Req, 1'b0);
    check_writes("t4");
    chk32("t4_hf_count", 32'(hf_cnt), 32'(exp_hf));

    // ---- 5: error completion after a short burst, then recovery
    ra = $urandom;
    send_go(ra);
    do_burst(ra, 20, 1, 0, 0, -1, -1, 0, -1, 0);
    @(negedge clk);
    chk1("t5_rd_error", rd_error, 1'b1);
    chk1("t5_busy_low", busy, 1'b0);
    @(negedge clk);
    check_writes("t5a");
    chk32("t5_no_hf", 32'(hf_cnt), 32'(exp_hf));
    ra = $urandom;
    send_go(ra);
    do_burst(ra, BW, 0, 0, 0, -1, -1, 0, -1, 0);
    exp_hf++;
    repeat (2) @(negedge clk);
    chk1("t5_rd_error_sticky", rd_error, 1'b1);
    check_writes("t5b");
    chk32("t5_hf_count", 32'(hf_cnt), 32'(exp_hf));

    // ---- 6: reset mid-transfer
    ra = $urandom;
    send_go(ra);
    do_burst(ra, BW, 0, 0, 0, 30, -1, 0, -1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk1("t6_req", IP2Bus_MstRd_Req, 1'b0);
    chk1("t6_dst_rdy_n", IP2Bus_MstRd_dst_rdy_n, 1'b1);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_rd_error_clr", rd_error, 1'b0);
    chk1("t6_overrun_clr", req_overrun, 1'b0);
    check_writes("t6a");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk32("t6_no_hf", 32'(hf_cnt), 32'(exp_hf));
    ra = $urandom;
    send_go(ra);
    do_burst(ra, BW, 0, 0, 0, -1, -1, 0, -1, 0);
    exp_hf++;
    repeat (2) @(negedge clk);
    check_writes("t6b");
    chk32("t6_hf_count", 32'(hf_cnt), 32'(exp_hf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
